// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency sweep controller.
// Holds the bus widths, the sequencer state encoding, the target-select
// constants and the latched sweep configuration record.
// Optional build macro used by the consumers: DDS_SWEEP_TRIANGLE_EN.
package dds_pkg;

  localparam int unsigned FCW_W   = 64;
  localparam int unsigned STEP_W  = 16;
  localparam int unsigned DWELL_W = 24;

  localparam logic TGT_CAR = 1'b0;
  localparam logic TGT_MOD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sweep configuration captured in IDLE and held for the whole sweep.
  typedef struct packed {
    logic [FCW_W-1:0]   start_fcw;
    logic [FCW_W-1:0]   step_fcw;
    logic [STEP_W-1:0]  num_steps;
    logic [DWELL_W-1:0] dwell;
    logic               loop_en;
    logic               target;
    logic               tri_en;
  } sweep_cfg_t;

  // Dwell counter reload: a programmed dwell of 0 behaves as 1.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that times how long each FCW value is held.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   load        - load counter with load_val (wins over en)
//   load_val    - reload value
//   en          - decrement while non-zero
//   zero_c      - counter is zero (combinational decode of the count)
module dds_dwell_timer
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero_c
);

  logic [DWELL_W-1:0] cnt_q;

  // Count register; saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Programmable frequency sweep sequencer for the carrier and modulator
// phase accumulators. A configuration is latched in IDLE; run starts the
// sweep, which steps the target FCW from start by step_fcw, holding each
// value for max(dwell,1) cycles, optionally looping.
// Build macro: DDS_SWEEP_TRIANGLE_EN adds cfg_tri (up-then-down sweep).
// Ports:
//   clk, rst_n          - accumulator clock, synchronous active-low reset
//   cfg_valid/cfg_ready - configuration handshake (ready in IDLE only)
//   cfg_*               - sweep configuration fields
//   run, abort          - level controls
//   freq_c_carrier/modu - FCW outputs (registered)
//   fcw_update          - pulse when an FCW output is written
//   step_idx            - current step index
//   busy                - sweep in DWELL
//   done                - pulse on entering DONE
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter logic [FCW_W-1:0] CAR_RST_FCW = '0,
  parameter logic [FCW_W-1:0] MOD_RST_FCW = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FCW_W-1:0]   cfg_start_fcw,
  input  logic [FCW_W-1:0]   cfg_step_fcw,
  input  logic [STEP_W-1:0]  cfg_num_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               cfg_target,
`ifdef DDS_SWEEP_TRIANGLE_EN
  input  logic               cfg_tri,
`endif
  input  logic               run,
  input  logic               abort,
  output logic [FCW_W-1:0]   freq_c_carrier,
  output logic [FCW_W-1:0]   freq_c_modu,
  output logic               fcw_update,
  output logic [STEP_W-1:0]  step_idx,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_nxt;
  sweep_cfg_t         cfg_q, cfg_nxt, cfg_in;
  logic [FCW_W-1:0]   car_q, car_nxt;
  logic [FCW_W-1:0]   mod_q, mod_nxt;
  logic [STEP_W-1:0]  idx_q, idx_nxt;
  logic               down_q, down_nxt;
  logic               upd_q, upd_nxt;
  logic               done_q, done_nxt;
  logic               ready_q, busy_q;

  logic               tmr_load, tmr_en, tmr_zero_c;
  logic               fcw_set;
  logic [FCW_W-1:0]   fcw_cur, fcw_new;

  // Assemble the configuration record from the input fields.
  always_comb begin
    cfg_in.start_fcw = cfg_start_fcw;
    cfg_in.step_fcw  = cfg_step_fcw;
    cfg_in.num_steps = cfg_num_steps;
    cfg_in.dwell     = cfg_dwell;
    cfg_in.loop_en   = cfg_loop;
    cfg_in.target    = cfg_target;
`ifdef DDS_SWEEP_TRIANGLE_EN
    cfg_in.tri_en    = cfg_tri;
`else
    cfg_in.tri_en    = 1'b0;
`endif
  end

  dds_dwell_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (dwell_reload(cfg_q.dwell)),
    .en       (tmr_en),
    .zero_c   (tmr_zero_c)
  );

  assign fcw_cur = (cfg_q.target == TGT_MOD) ? mod_q : car_q;

  // Next-state and datapath decisions; abort overrides every state.
  always_comb begin
    state_nxt = state_q;
    cfg_nxt   = cfg_q;
    car_nxt   = car_q;
    mod_nxt   = mod_q;
    idx_nxt   = idx_q;
    down_nxt  = down_q;
    upd_nxt   = 1'b0;
    done_nxt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    fcw_set   = 1'b0;
    fcw_new   = fcw_cur;

    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      down_nxt  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            cfg_nxt   = cfg_in;
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (run) begin
            fcw_set   = 1'b1;
            fcw_new   = cfg_q.start_fcw;
            idx_nxt   = '0;
            down_nxt  = 1'b0;
            tmr_load  = 1'b1;
            state_nxt = DWELL;
          end
        end
        DWELL: begin
          if (!tmr_zero_c) begin
            tmr_en = 1'b1;
          end else if (!down_q && (idx_q < cfg_q.num_steps)) begin
            fcw_set  = 1'b1;
            fcw_new  = fcw_cur + cfg_q.step_fcw;
            idx_nxt  = idx_q + STEP_W'(1);
            tmr_load = 1'b1;
          end else if (!down_q && cfg_q.tri_en && (cfg_q.num_steps != '0)) begin
            // Peak reached: turn around without repeating the peak value.
            fcw_set  = 1'b1;
            fcw_new  = fcw_cur - cfg_q.step_fcw;
            idx_nxt  = idx_q - STEP_W'(1);
            down_nxt = 1'b1;
            tmr_load = 1'b1;
          end else if (down_q && (idx_q != '0)) begin
            fcw_set  = 1'b1;
            fcw_new  = fcw_cur - cfg_q.step_fcw;
            idx_nxt  = idx_q - STEP_W'(1);
            tmr_load = 1'b1;
          end else if (cfg_q.loop_en) begin
            fcw_set  = 1'b1;
            fcw_new  = cfg_q.start_fcw;
            idx_nxt  = '0;
            down_nxt = 1'b0;
            tmr_load = 1'b1;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Only the configured target output is ever written.
    if (fcw_set) begin
      upd_nxt = 1'b1;
      if (cfg_q.target == TGT_MOD) begin
        mod_nxt = fcw_new;
      end else begin
        car_nxt = fcw_new;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      car_q   <= CAR_RST_FCW;
      mod_q   <= MOD_RST_FCW;
      idx_q   <= '0;
      down_q  <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cfg_q   <= cfg_nxt;
      car_q   <= car_nxt;
      mod_q   <= mod_nxt;
      idx_q   <= idx_nxt;
      down_q  <= down_nxt;
      upd_q   <= upd_nxt;
      done_q  <= done_nxt;
      ready_q <= (state_nxt == IDLE);
      busy_q  <= (state_nxt == DWELL);
    end
  end

  assign freq_c_carrier = car_q;
  assign freq_c_modu    = mod_q;
  assign fcw_update     = upd_q;
  assign step_idx       = idx_q;
  assign done           = done_q;
  assign cfg_ready      = ready_q;
  assign busy           = busy_q;

endmodule
